// File: rtl/dmem_wbuf.sv
// Data memory for the M stage: word RAM with a slow write port behind an in-order
// write buffer. Loads read combinationally and are forwarded from the youngest
// buffered store to the same word.
module dmem_wbuf #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WB_DEPTH    = 4,
   parameter int unsigned WRITE_LAT   = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            MemWriteM,
   input  logic [31:0]                     ALUResultM,
   input  logic [31:0]                     WriteDataM,
   output logic [31:0]                     ReadDataM,
   output logic                            MemStallM,
   output logic [$clog2(WB_DEPTH+1)-1:0]   WBCount,
   output logic                            WBEmpty
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = $clog2(WB_DEPTH);
   localparam int unsigned CW = $clog2(WB_DEPTH + 1);
   localparam int unsigned LW = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [31:0]   data;
   } entry_t;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [LW-1:0] lat;
   logic [LW-1:0] lat_nxt;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [PW-1:0] pos;
   logic [AW-1:0] idx;
   logic          pop;
   logic          enq;
   logic          unused_addr_bits;

   entry_t        fifo [WB_DEPTH];
   logic [31:0]   mem  [DEPTH_WORDS];

   assign idx              = ALUResultM[AW+1:2];
   assign unused_addr_bits = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};

   // The head entry commits to RAM on the last cycle of its write latency.
   assign pop       = (state == BUSY) && (lat == '0);
   assign enq       = MemWriteM && ((count < CW'(WB_DEPTH)) || pop);
   assign MemStallM = MemWriteM && (count == CW'(WB_DEPTH)) && !pop;
   assign WBCount   = count;
   assign WBEmpty   = (count == '0);

   // Occupancy after this edge; a simultaneous pop and enqueue leaves it unchanged.
   always_comb begin
      count_nxt = count;
      if (enq && !pop) begin
         count_nxt = count + CW'(1);
      end else if (!enq && pop) begin
         count_nxt = count - CW'(1);
      end
   end

   // Drain FSM state and latency counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         lat   <= '0;
      end else begin
         state <= state_nxt;
         lat   <= lat_nxt;
      end
   end

   // Drain FSM next state: count down the write latency, reload while entries remain.
   always_comb begin
      state_nxt = state;
      lat_nxt   = lat;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt = BUSY;
               lat_nxt   = LW'(WRITE_LAT - 1);
            end
         end
         BUSY: begin
            if (lat != '0) begin
               lat_nxt = lat - LW'(1);
            end else if (count_nxt != '0) begin
               lat_nxt = LW'(WRITE_LAT - 1);
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            lat_nxt   = '0;
         end
      endcase
   end

   // Buffer pointers and occupancy; reset discards all buffered stores.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop) begin
            head <= head + PW'(1);
         end
         if (enq) begin
            tail <= tail + PW'(1);
         end
         count <= count_nxt;
      end
   end

   // Buffer payload storage.
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo[tail] <= '{idx: idx, data: WriteDataM};
      end
   end

   // RAM write port; the RAM itself is never reset.
   always_ff @(posedge clk) begin
      if (pop) begin
         mem[fifo[head].idx] <= fifo[head].data;
      end
   end

   // Load path: RAM word, overridden by matching entries from oldest to youngest.
   always_comb begin
      ReadDataM = mem[idx];
      pos       = '0;
      for (int k = 0; k < int'(WB_DEPTH); k++) begin
         pos = head + PW'(k);
         if ((CW'(k) < count) && (fifo[pos].idx == idx)) begin
            ReadDataM = fifo[pos].data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: two instances (write latency 2 and 4) checked against a
// queue-based reference model with an absolute-time commit schedule.
module tb_dmem_wbuf;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] d;
   } ent_t;

   logic        clk;
   logic        reset;
   logic        we0, we1;
   logic [31:0] addr0, addr1, data0, data1;
   logic [31:0] rd0, rd1;
   logic        stall0, stall1;
   logic [2:0]  cnt0, cnt1;
   logic        empty0, empty1;

   ent_t        q0[$];
   ent_t        q1[$];
   logic [31:0] mram0 [64];
   logic [31:0] mram1 [64];
   longint      commit_at [2];
   longint      lat_of [2];
   longint      t;
   int          total;
   int          bad;

   dmem_wbuf #(.DEPTH_WORDS(64), .WB_DEPTH(4), .WRITE_LAT(2)) dut (
      .clk(clk), .reset(reset), .MemWriteM(we0), .ALUResultM(addr0), .WriteDataM(data0),
      .ReadDataM(rd0), .MemStallM(stall0), .WBCount(cnt0), .WBEmpty(empty0));

   dmem_wbuf #(.DEPTH_WORDS(64), .WB_DEPTH(4), .WRITE_LAT(4)) dut4 (
      .clk(clk), .reset(reset), .MemWriteM(we1), .ALUResultM(addr1), .WriteDataM(data1),
      .ReadDataM(rd1), .MemStallM(stall1), .WBCount(cnt1), .WBEmpty(empty1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int qsz(int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [31:0] m_read(int i, logic [31:0] a);
      logic [5:0] x;
      x = a[7:2];
      if (i == 0) begin
         for (int k = q0.size() - 1; k >= 0; k--) if (q0[k].idx == x) return q0[k].d;
         return mram0[x];
      end
      for (int k = q1.size() - 1; k >= 0; k--) if (q1[k].idx == x) return q1[k].d;
      return mram1[x];
   endfunction

   function automatic bit m_pop(int i);
      return commit_at[i] == t;
   endfunction

   function automatic bit m_stall(int i, bit w);
      return w && (qsz(i) == 4) && !m_pop(i);
   endfunction

   function automatic logic [31:0] rdv(int i);
      return (i == 0) ? rd0 : rd1;
   endfunction

   function automatic logic stallv(int i);
      return (i == 0) ? stall0 : stall1;
   endfunction

   function automatic logic [2:0] cntv(int i);
      return (i == 0) ? cnt0 : cnt1;
   endfunction

   function automatic logic emptyv(int i);
      return (i == 0) ? empty0 : empty1;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      commit_at[0] = -1;
      commit_at[1] = -1;
   endtask

   // Apply one clock edge to the model for both instances.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit          w, p, acc;
         logic [31:0] a, d;
         int          pre;
         ent_t        e;
         w   = (i == 0) ? we0 : we1;
         a   = (i == 0) ? addr0 : addr1;
         d   = (i == 0) ? data0 : data1;
         pre = qsz(i);
         p   = m_pop(i);
         acc = w && ((pre < 4) || p);
         if (p) begin
            if (i == 0) begin e = q0.pop_front(); mram0[e.idx] = e.d; end
            else        begin e = q1.pop_front(); mram1[e.idx] = e.d; end
         end
         if (acc) begin
            e.idx = a[7:2];
            e.d   = d;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
         end
         if (p) commit_at[i] = (qsz(i) > 0) ? t + lat_of[i] : -1;
         else if ((commit_at[i] < 0) && (pre > 0)) commit_at[i] = t + lat_of[i];
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_in(int i, bit w, logic [31:0] a, logic [31:0] d);
      if (i == 0) begin we0 = w; addr0 = a; data0 = d; end
      else        begin we1 = w; addr1 = a; data1 = d; end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_edge();
      t++;
      #1;
   endtask

   task automatic store(int i, logic [31:0] a, logic [31:0] d);
      bit acc;
      for (int n = 0; n < 40; n++) begin
         set_in(i, 1'b1, a, d);
         acc = !m_stall(i, 1'b1);
         tick();
         if (acc) break;
      end
      set_in(i, 1'b0, a, 32'h0);
   endtask

   task automatic drain(int i);
      for (int n = 0; (n < 200) && (qsz(i) > 0); n++) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      set_in(0, 1'b1, 32'h20, 32'h1111_1111);
      set_in(1, 1'b1, 32'h24, 32'h2222_2222);
      #2;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 2; i++) begin
            total++; if (cntv(i) !== 3'd0) begin bad++; $display("FAIL reset_cnt%0d got=%0d exp=0", i, cntv(i)); end
            total++; if (emptyv(i) !== 1'b1) begin bad++; $display("FAIL reset_empty%0d got=%b exp=1", i, emptyv(i)); end
            total++; if (stallv(i) !== 1'b0) begin bad++; $display("FAIL reset_stall%0d got=%b exp=0", i, stallv(i)); end
         end
         @(posedge clk); #1;
      end
      set_in(0, 1'b0, 32'h0, 32'h0);
      set_in(1, 1'b0, 32'h0, 32'h0);
      #1;
      reset = 1'b1;
      model_reset();
      t = 0;
   endtask

   task automatic test_preload(int i);
      for (int k = 0; k < 64; k++) store(i, 32'(k * 4), $urandom);
      drain(i);
      set_in(i, 1'b0, 32'h0, 32'h0);
      #1;
      total++; if (emptyv(i) !== 1'b1) begin bad++; $display("FAIL preload_empty%0d got=%b exp=1", i, emptyv(i)); end
      for (int k = 0; k < 64; k += 7) begin
         set_in(i, 1'b0, 32'(k * 4), 32'h0);
         #1;
         total++; if (rdv(i) !== m_read(i, 32'(k * 4))) begin bad++; $display("FAIL preload_rd%0d got=%h exp=%h", i, rdv(i), m_read(i, 32'(k * 4))); end
      end
   endtask

   task automatic test_forward();
      store(0, 32'h20, 32'hDEAD_BEEF);
      set_in(0, 1'b0, 32'h20, 32'h0);
      #1;
      total++; if (rd0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fwd_rd got=%h exp=deadbeef", rd0); end
      total++; if (cnt0 !== 3'd1) begin bad++; $display("FAIL fwd_cnt got=%0d exp=1", cnt0); end
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (rd0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fwd_rd_c%0d got=%h exp=deadbeef", c, rd0); end
         total++; if (cnt0 !== 3'(qsz(0))) begin bad++; $display("FAIL fwd_cnt_c%0d got=%0d exp=%0d", c, cnt0, qsz(0)); end
      end
      total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL fwd_empty got=%b exp=1", empty0); end
   endtask

   task automatic test_back_to_back();
      store(0, 32'h40, 32'h1);
      store(0, 32'h40, 32'h2);
      for (int c = 0; c < 6; c++) begin
         set_in(0, 1'b0, 32'h40, 32'h0);
         #1;
         total++; if (rd0 !== 32'h2) begin bad++; $display("FAIL b2b_rd_c%0d got=%h exp=2", c, rd0); end
         total++; if (cnt0 !== 3'(qsz(0))) begin bad++; $display("FAIL b2b_cnt_c%0d got=%0d exp=%0d", c, cnt0, qsz(0)); end
         tick();
      end
      drain(0);
      #1;
      total++; if (rd0 !== 32'h2) begin bad++; $display("FAIL b2b_rd_after got=%h exp=2", rd0); end
      total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty0); end
   endtask

   task automatic test_stall_lat4();
      logic [31:0] vals [6];
      int          k;
      bit          exp_stall, dut_saw;
      k = 0;
      dut_saw = 1'b0;
      for (int j = 0; j < 6; j++) vals[j] = $urandom;
      for (int n = 0; (n < 60) && (k < 6); n++) begin
         set_in(1, 1'b1, 32'h80 + 32'(k * 4), vals[k]);
         #1;
         exp_stall = m_stall(1, 1'b1);
         total++; if (stall1 !== exp_stall) begin bad++; $display("FAIL l4_stall_n%0d got=%b exp=%b", n, stall1, exp_stall); end
         total++; if (cnt1 > 3'd4 || cnt1 !== 3'(qsz(1))) begin bad++; $display("FAIL l4_cnt_n%0d got=%0d exp=%0d", n, cnt1, qsz(1)); end
         if (stall1 === 1'b1) dut_saw = 1'b1;
         tick();
         if (!exp_stall) k++;
      end
      set_in(1, 1'b0, 32'h0, 32'h0);
      total++; if (k != 6) begin bad++; $display("FAIL l4_accept got=%0d exp=6", k); end
      total++; if (dut_saw !== 1'b1) begin bad++; $display("FAIL l4_saw_stall got=%b exp=1", dut_saw); end
      drain(1);
      for (int j = 0; j < 6; j++) begin
         set_in(1, 1'b0, 32'h80 + 32'(j * 4), 32'h0);
         #1;
         total++; if (rd1 !== vals[j]) begin bad++; $display("FAIL l4_ram%0d got=%h exp=%h", j, rd1, vals[j]); end
      end
      total++; if (empty1 !== 1'b1) begin bad++; $display("FAIL l4_empty got=%b exp=1", empty1); end
   endtask

   task automatic test_full_pop();
      int k;
      bit exp_stall, full_pop, seen;
      k = 0;
      seen = 1'b0;
      for (int n = 0; (n < 60) && (k < 10); n++) begin
         set_in(0, 1'b1, 32'($urandom_range(0, 1023)), $urandom);
         #1;
         exp_stall = m_stall(0, 1'b1);
         full_pop  = (qsz(0) == 4) && m_pop(0);
         total++; if (stall0 !== exp_stall) begin bad++; $display("FAIL fp_stall_n%0d got=%b exp=%b", n, stall0, exp_stall); end
         tick();
         if (full_pop) begin
            seen = 1'b1;
            total++; if (cnt0 !== 3'd4) begin bad++; $display("FAIL fp_cnt_n%0d got=%0d exp=4", n, cnt0); end
         end
         if (!exp_stall) k++;
      end
      set_in(0, 1'b0, 32'h0, 32'h0);
      total++; if (!seen || k != 10) begin bad++; $display("FAIL fp_cover got=%0d exp=10", k); end
      drain(0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] old [3];
      for (int j = 0; j < 3; j++) old[j] = mram0[40 + j];
      for (int j = 0; j < 3; j++) store(0, 32'(160 + j * 4), ~old[j]);
      reset = 1'b0;
      model_reset();
      set_in(0, 1'b1, 32'h0, 32'h5);
      #1;
      total++; if (cnt0 !== 3'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", cnt0); end
      total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL rm_empty got=%b exp=1", empty0); end
      total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b exp=0", stall0); end
      tick();
      set_in(0, 1'b0, 32'h0, 32'h0);
      #1;
      reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         set_in(0, 1'b0, 32'(160 + j * 4), 32'h0);
         #1;
         total++; if (rd0 !== old[j]) begin bad++; $display("FAIL rm_ram%0d got=%h exp=%h", j, rd0, old[j]); end
      end
   endtask

   task automatic test_alias();
      store(0, 32'h100, 32'hA5A5_A5A5);
      set_in(0, 1'b0, 32'h0, 32'h0);
      #1;
      total++; if (rd0 !== 32'hA5A5_A5A5) begin bad++; $display("FAIL alias_fwd got=%h exp=a5a5a5a5", rd0); end
      drain(0);
      #1;
      total++; if (rd0 !== 32'hA5A5_A5A5) begin bad++; $display("FAIL alias_ram got=%h exp=a5a5a5a5", rd0); end
      set_in(0, 1'b0, 32'h23, 32'h0);
      #1;
      total++; if (rd0 !== m_read(0, 32'h20)) begin bad++; $display("FAIL alias_23 got=%h exp=%h", rd0, m_read(0, 32'h20)); end
      set_in(0, 1'b0, 32'h20, 32'h0);
      #1;
      total++; if (rd0 !== m_read(0, 32'h20)) begin bad++; $display("FAIL alias_20 got=%h exp=%h", rd0, m_read(0, 32'h20)); end
   endtask

   task automatic test_random(int i);
      bit          w;
      logic [31:0] a;
      for (int n = 0; n < 300; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 1023));
         set_in(i, w, a, $urandom);
         #1;
         total++; if (rdv(i) !== m_read(i, a)) begin bad++; $display("FAIL rnd%0d_rd n=%0d got=%h exp=%h", i, n, rdv(i), m_read(i, a)); end
         total++; if (stallv(i) !== m_stall(i, w)) begin bad++; $display("FAIL rnd%0d_stall n=%0d got=%b exp=%b", i, n, stallv(i), m_stall(i, w)); end
         total++; if (cntv(i) !== 3'(qsz(i))) begin bad++; $display("FAIL rnd%0d_cnt n=%0d got=%0d exp=%0d", i, n, cntv(i), qsz(i)); end
         total++; if (emptyv(i) !== (qsz(i) == 0)) begin bad++; $display("FAIL rnd%0d_empty n=%0d got=%b exp=%b", i, n, emptyv(i), qsz(i) == 0); end
         tick();
      end
      set_in(i, 1'b0, 32'h0, 32'h0);
      drain(i);
      for (int k = 0; k < 64; k++) begin
         set_in(i, 1'b0, 32'(k * 4), 32'h0);
         #1;
         total++; if (rdv(i) !== m_read(i, 32'(k * 4))) begin bad++; $display("FAIL rnd%0d_final k=%0d got=%h exp=%h", i, k, rdv(i), m_read(i, 32'(k * 4))); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      t     = 0;
      lat_of[0] = 2;
      lat_of[1] = 4;
      model_reset();
      set_in(0, 1'b0, 32'h0, 32'h0);
      set_in(1, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_preload(0);
      test_preload(1);
      test_forward();
      test_back_to_back();
      test_stall_lat4();
      test_full_pop();
      test_reset_mid();
      test_alias();
      test_random(0);
      test_random(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
